line_fill_responder: RTL and testbench



---
 rtl/line_fill_responder.sv | 101 ++++++++++
 tb/tb_line_fill_responder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/line_fill_responder.sv
// Line-refill responder: fetches the four words of a 16-byte line from a 32-bit
// synchronous SRAM and returns them as one 128-bit line with a single valid pulse.
module line_fill_responder #(
  parameter int WORD_ADDR_W   = 12,
  parameter int EXTRA_LATENCY = 0
) (
  input  logic                   clk_i,
  input  logic                   resetn_i,
  input  logic [31:0]            mem_addr_i,
  input  logic                   mem_read_en_i,
  output logic                   mem_read_valid_o,
  output logic [3:0][31:0]       mem_read_data_o,
  output logic                   busy_o,
  output logic                   sram_re_o,
  output logic [WORD_ADDR_W-1:0] sram_add_o,
  input  logic [31:0]            sram_d_i
);

  // state | meaning
  // IDLE  | waiting for a line request
  // WAIT  | extra-latency countdown before the first SRAM read
  // FETCH | issuing word reads 0..3, capturing the word read the cycle before
  // LAST  | capturing word 3, no read issued
  // DONE  | line valid for this one cycle
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_FETCH, S_LAST, S_DONE} state_t;

  localparam int         LINE_W    = WORD_ADDR_W - 2;
  localparam logic [7:0] WAIT_LOAD = (EXTRA_LATENCY > 0) ? 8'(EXTRA_LATENCY - 1) : 8'd0;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [LINE_W-1:0]      r_line;
  logic [1:0]             r_k;
  logic [1:0]             r_j;
  logic [7:0]             r_wait_cnt;
  logic [WORD_ADDR_W-1:0] r_add_hold;
  logic                   w_accept;
  logic                   w_unused;

  assign w_unused = ^{mem_addr_i[31:WORD_ADDR_W+2], mem_addr_i[3:0]};
  assign w_accept = (r_state == S_IDLE) && mem_read_en_i;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (mem_read_en_i) w_state_nxt = (EXTRA_LATENCY > 0) ? S_WAIT : S_FETCH;
      S_WAIT:  if (r_wait_cnt == 8'd0) w_state_nxt = S_FETCH;
      S_FETCH: if (r_k == 2'd3) w_state_nxt = S_LAST;
      S_LAST:  w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign sram_re_o        = (r_state == S_FETCH);
  assign sram_add_o       = sram_re_o ? {r_line, r_k} : r_add_hold;
  assign mem_read_valid_o = (r_state == S_DONE);
  assign busy_o           = (r_state != S_IDLE);

  // SRAM data lags the read by one cycle, so FETCH k stores word k-1 and LAST stores word 3.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_line          <= '0;
      r_k             <= '0;
      r_j             <= '0;
      r_wait_cnt      <= '0;
      r_add_hold      <= '0;
      mem_read_data_o <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_line     <= mem_addr_i[WORD_ADDR_W+1:4];
            r_k        <= 2'd0;
            r_j        <= 2'd0;
            r_wait_cnt <= WAIT_LOAD;
          end
        end
        S_WAIT: begin
          if (r_wait_cnt != 8'd0) r_wait_cnt <= r_wait_cnt - 8'd1;
        end
        S_FETCH: begin
          r_k        <= r_k + 2'd1;
          r_add_hold <= {r_line, r_k};
          if (r_k != 2'd0) begin
            mem_read_data_o[r_j] <= sram_d_i;
            r_j                  <= r_j + 2'd1;
          end
        end
        S_LAST: mem_read_data_o[3] <= sram_d_i;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_line_fill_responder.sv
// Directed bench for line_fill_responder: two instances (no extra latency and
// three cycles of extra latency), each with its own synchronous SRAM model.
module tb_line_fill_responder;

  logic             clk;
  logic             rstn;
  logic             en     [2];
  logic [31:0]      addr   [2];
  logic             valid  [2];
  logic [3:0][31:0] rdata  [2];
  logic             busy   [2];
  logic             re     [2];
  logic [11:0]      add    [2];
  logic [31:0]      sq     [2];

  int checks = 0;
  int errors = 0;

  line_fill_responder #(.WORD_ADDR_W(12), .EXTRA_LATENCY(0)) u_dut0 (
    .clk_i(clk), .resetn_i(rstn), .mem_addr_i(addr[0]), .mem_read_en_i(en[0]),
    .mem_read_valid_o(valid[0]), .mem_read_data_o(rdata[0]), .busy_o(busy[0]),
    .sram_re_o(re[0]), .sram_add_o(add[0]), .sram_d_i(sq[0]));

  line_fill_responder #(.WORD_ADDR_W(12), .EXTRA_LATENCY(3)) u_dut1 (
    .clk_i(clk), .resetn_i(rstn), .mem_addr_i(addr[1]), .mem_read_en_i(en[1]),
    .mem_read_valid_o(valid[1]), .mem_read_data_o(rdata[1]), .busy_o(busy[1]),
    .sram_re_o(re[1]), .sram_add_o(add[1]), .sram_d_i(sq[1]));

  // SRAM contents: word i holds 0x9C + i, so words 4..7 are 0xA0..0xA3.
  always @(posedge clk) if (re[0]) sq[0] <= 32'h9C + 32'(add[0]);
  always @(posedge clk) if (re[1]) sq[1] <= 32'h9C + 32'(add[1]);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_req(input int d, input int lat, input logic [31:0] a,
                         input logic [11:0] base, input logic [127:0] exp_data);
    logic exp_re;
    @(negedge clk);
    en[d]   = 1'b1;
    addr[d] = a;
    @(posedge clk);
    for (int c = 1; c <= 7 + lat; c++) begin
      @(negedge clk);
      exp_re = (c >= lat + 1) && (c <= lat + 4);
      chk($sformatf("d%0d a%0h re c%0d", d, a, c), 128'(re[d]), 128'(exp_re));
      if (exp_re)
        chk($sformatf("d%0d a%0h add c%0d", d, a, c), 128'(add[d]), 128'(base + 12'(c - 1 - lat)));
      chk($sformatf("d%0d a%0h valid c%0d", d, a, c), 128'(valid[d]), 128'(c == 6 + lat));
      chk($sformatf("d%0d a%0h busy c%0d", d, a, c), 128'(busy[d]), 128'(c <= 6 + lat));
      if (c == 6 + lat)
        chk($sformatf("d%0d a%0h data", d, a), rdata[d], exp_data);
      if (c == 1) en[d] = 1'b0;
    end
  endtask

  typedef struct {
    int           d;
    int           lat;
    logic [31:0]  addr;
    logic [11:0]  base;
    logic [127:0] data;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{0, 0, 32'h0000_0010, 12'd4,     128'h000000A3_000000A2_000000A1_000000A0};
    vecs[1] = '{1, 3, 32'h0000_0010, 12'd4,     128'h000000A3_000000A2_000000A1_000000A0};
    vecs[2] = '{0, 0, 32'h0000_401C, 12'd4,     128'h000000A3_000000A2_000000A1_000000A0};
    vecs[3] = '{0, 0, 32'h0000_3FF0, 12'hFFC,   128'h0000109B_0000109A_00001099_00001098};
    vecs[4] = '{1, 3, 32'h0000_0020, 12'd8,     128'h000000A7_000000A6_000000A5_000000A4};

    rstn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      en[d]   = 1'b0;
      addr[d] = 32'h0;
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Reset then idle for 20 cycles.
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("idle d%0d re c%0d", d, c),    128'(re[d]),    128'(0));
        chk($sformatf("idle d%0d valid c%0d", d, c), 128'(valid[d]), 128'(0));
        chk($sformatf("idle d%0d busy c%0d", d, c),  128'(busy[d]),  128'(0));
        chk($sformatf("idle d%0d add c%0d", d, c),   128'(add[d]),   128'(0));
        chk($sformatf("idle d%0d data c%0d", d, c),  rdata[d],       128'(0));
      end
    end

    for (int i = 0; i < 5; i++)
      run_req(vecs[i].d, vecs[i].lat, vecs[i].addr, vecs[i].base, vecs[i].data);

    // Request held high: 0x20 accepted in cycle 0, 0x30 in cycle 7; en ignored while busy.
    @(negedge clk);
    en[0]   = 1'b1;
    addr[0] = 32'h20;
    @(posedge clk);
    for (int c = 1; c <= 14; c++) begin
      logic exp_re;
      @(negedge clk);
      exp_re = (c >= 1 && c <= 4) || (c >= 8 && c <= 11);
      chk($sformatf("hold re c%0d", c),    128'(re[0]),    128'(exp_re));
      chk($sformatf("hold valid c%0d", c), 128'(valid[0]), 128'(c == 6 || c == 13));
      chk($sformatf("hold busy c%0d", c),  128'(busy[0]),  128'(c != 7 && c <= 13));
      if (c >= 1 && c <= 4)  chk($sformatf("hold add c%0d", c), 128'(add[0]), 128'(8 + c - 1));
      if (c >= 8 && c <= 11) chk($sformatf("hold add c%0d", c), 128'(add[0]), 128'(12 + c - 8));
      if (c == 6)  chk("hold data 0x20", rdata[0], 128'h000000A7_000000A6_000000A5_000000A4);
      if (c == 13) chk("hold data 0x30", rdata[0], 128'h000000AB_000000AA_000000A9_000000A8);
      if (c == 1)  addr[0] = 32'h30;
      if (c == 13) en[0] = 1'b0;
    end

    // Reset in the middle of a fill.
    @(negedge clk);
    en[0]   = 1'b1;
    addr[0] = 32'h20;
    @(posedge clk);
    @(negedge clk);
    en[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre-reset re", 128'(re[0]), 128'(1));
    rstn = 1'b0;
    #1;
    chk("rst re",    128'(re[0]),    128'(0));
    chk("rst valid", 128'(valid[0]), 128'(0));
    chk("rst busy",  128'(busy[0]),  128'(0));
    chk("rst add",   128'(add[0]),   128'(0));
    chk("rst data",  rdata[0],       128'(0));
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("post-rst valid c%0d", c), 128'(valid[0]), 128'(0));
      chk($sformatf("post-rst busy c%0d", c),  128'(busy[0]),  128'(0));
    end
    run_req(0, 0, 32'h30, 12'd12, 128'h000000AB_000000AA_000000A9_000000A8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
